// File: rtl/sram_1rw1r_init.sv
// 1RW+1R synchronous SRAM model: byte-masked writes, 1/2-cycle reads,
// same-address collision policy and an optional zero-fill engine after reset.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   ready                 array usable (clear finished)
//   p0_en/we/mask/addr    port 0 read/write request
//   p0_wdata              port 0 write data
//   p0_rdata/p0_rvalid    port 0 read result
//   p1_en/addr            port 1 read request
//   p1_rdata/p1_rvalid    port 1 read result
//   collision             p1 read hit a same-cycle p0 write
module sram_1rw1r_init #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 9,
  parameter int DEPTH        = 1 << ADDR_W,
  parameter int MASK_W       = DATA_W / 8,
  parameter int READ_LAT     = 1,
  parameter bit BYPASS       = 1'b1,
  parameter bit CLEAR_ON_RST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              ready,
  input  logic              p0_en,
  input  logic              p0_we,
  input  logic [MASK_W-1:0] p0_mask,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_rvalid,
  input  logic              p1_en,
  input  logic [ADDR_W-1:0] p1_addr,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_rvalid,
  output logic              collision
);

  localparam int LANE_W = DATA_W / MASK_W;
  localparam logic [ADDR_W:0] DEPTH_X =
    (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(DEPTH - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [DATA_W-1:0] bmask;
  logic              p0_in, p1_in;
  logic              wr, rd0, rd1, col;
  logic [DATA_W-1:0] d0, d1_old, d1;

  logic              v0_a, v1_a, c_a;
  logic [DATA_W-1:0] d0_a, d1_a;

  assign ready = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      if (CLEAR_ON_RST) state <= INIT;
      else              state <= RUN;
    end else if (state == INIT) begin
      cnt <= cnt + 1'b1;
      if (cnt == LAST) state <= RUN;
    end
  end

  always_comb begin
    bmask = '0;
    for (int i = 0; i < MASK_W; i++)
      bmask[i*LANE_W +: LANE_W] =
        {LANE_W{p0_mask[i]}};
  end

  // Out-of-range addresses never alias onto
  // real words.
  assign p0_in = {1'b0, p0_addr} < DEPTH_X;
  assign p1_in = {1'b0, p1_addr} < DEPTH_X;

  assign wr  = ready & p0_en & p0_we & p0_in;
  assign rd0 = ready & p0_en & ~p0_we;
  assign rd1 = ready & p1_en;
  assign col = wr & rd1 & (p1_addr == p0_addr);

  assign d0     = p0_in ? mem[p0_addr] : '0;
  assign d1_old = p1_in ? mem[p1_addr] : '0;
  assign d1 = (BYPASS && col)
            ? (d1_old & ~bmask) | (p0_wdata & bmask)
            : d1_old;

  always_ff @(posedge clk) begin
    if (state == INIT)
      mem[cnt] <= '0;
    else if (wr)
      mem[p0_addr] <= (mem[p0_addr] & ~bmask)
                    | (p0_wdata & bmask);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_a <= 1'b0;
      v1_a <= 1'b0;
      c_a  <= 1'b0;
      d0_a <= '0;
      d1_a <= '0;
    end else begin
      v0_a <= rd0;
      v1_a <= rd1;
      c_a  <= col;
      if (rd0) d0_a <= d0;
      if (rd1) d1_a <= d1;
    end
  end

  if (READ_LAT == 2) begin : g_lat2
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        p0_rvalid <= 1'b0;
        p1_rvalid <= 1'b0;
        collision <= 1'b0;
        p0_rdata  <= '0;
        p1_rdata  <= '0;
      end else begin
        p0_rvalid <= v0_a;
        p1_rvalid <= v1_a;
        collision <= c_a;
        if (v0_a) p0_rdata <= d0_a;
        if (v1_a) p1_rdata <= d1_a;
      end
    end
  end else begin : g_lat1
    assign p0_rvalid = v0_a;
    assign p1_rvalid = v1_a;
    assign collision = c_a;
    assign p0_rdata  = d0_a;
    assign p1_rdata  = d1_a;
  end

endmodule

// File: tb/tb_sram_1rw1r_init.sv
// Bench for sram_1rw1r_init: two instances (512/LAT1/bypass and
// 300/LAT2/no-bypass) driven in lockstep against an array model.
module tb_sram_1rw1r_init;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        p0_en, p0_we, p1_en;
  logic [3:0]  p0_mask;
  logic [8:0]  p0_addr, p1_addr;
  logic [31:0] p0_wdata;

  logic        rdy_a, v0_a, v1_a, col_a;
  logic [31:0] d0_a, d1_a;
  logic        rdy_b, v0_b, v1_b, col_b;
  logic [31:0] d0_b, d1_b;

  sram_1rw1r_init u_a (
    .clk(clk), .rst_n(rst_n), .ready(rdy_a),
    .p0_en(p0_en), .p0_we(p0_we),
    .p0_mask(p0_mask), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_rdata(d0_a),
    .p0_rvalid(v0_a), .p1_en(p1_en),
    .p1_addr(p1_addr), .p1_rdata(d1_a),
    .p1_rvalid(v1_a), .collision(col_a)
  );

  sram_1rw1r_init #(
    .DEPTH(300), .READ_LAT(2), .BYPASS(1'b0)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .ready(rdy_b),
    .p0_en(p0_en), .p0_we(p0_we),
    .p0_mask(p0_mask), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_rdata(d0_b),
    .p0_rvalid(v0_b), .p1_en(p1_en),
    .p1_addr(p1_addr), .p1_rdata(d1_b),
    .p1_rvalid(v1_b), .collision(col_b)
  );

  typedef struct packed {
    logic        rdy, v0, v1, col;
    logic [31:0] d0, d1;
  } obs_t;

  int errors = 0;
  int checks = 0;
  int ecount = 0;
  int since_rel = 0;

  int dep [2] = '{512, 300};
  int lat [2] = '{1, 2};
  bit byp [2] = '{1'b1, 1'b0};

  logic [31:0] mdl [2][512];
  bit          ev0 [2][8192];
  bit          ev1 [2][8192];
  bit          ec  [2][8192];
  logic [31:0] ed0 [2][8192];
  logic [31:0] ed1 [2][8192];
  logic [31:0] ld0 [2];
  logic [31:0] ld1 [2];

  function automatic obs_t obs(int i);
    obs_t o;
    if (i == 0) begin
      o.rdy = rdy_a; o.v0 = v0_a; o.v1 = v1_a;
      o.col = col_a; o.d0 = d0_a; o.d1 = d1_a;
    end else begin
      o.rdy = rdy_b; o.v0 = v0_b; o.v1 = v1_b;
      o.col = col_b; o.d0 = d0_b; o.d1 = d1_b;
    end
    return o;
  endfunction

  function automatic logic [31:0] merge(
    logic [31:0] old, logic [31:0] nw,
    logic [3:0] m);
    logic [31:0] r = old;
    for (int l = 0; l < 4; l++)
      if (m[l]) r[8*l +: 8] = nw[8*l +: 8];
    return r;
  endfunction

  // Reset drops in-flight reads; INIT zero-fills.
  function automatic void flush();
    for (int i = 0; i < 2; i++) begin
      for (int t = ecount + 1; t < 8192; t++) begin
        ev0[i][t] = 1'b0;
        ev1[i][t] = 1'b0;
        ec[i][t]  = 1'b0;
      end
      for (int a = 0; a < 512; a++)
        mdl[i][a] = '0;
      ld0[i] = '0;
      ld1[i] = '0;
    end
    since_rel = 0;
  endfunction

  function automatic void model_edge();
    for (int i = 0; i < 2; i++) begin
      int vis = ecount + lat[i];
      logic [31:0] r;
      bit c;
      if (rst_n && since_rel >= dep[i]) begin
        if (p0_en && !p0_we) begin
          r = (int'(p0_addr) < dep[i])
            ? mdl[i][p0_addr] : 32'h0;
          ev0[i][vis] = 1'b1;
          ed0[i][vis] = r;
        end
        if (p1_en) begin
          r = (int'(p1_addr) < dep[i])
            ? mdl[i][p1_addr] : 32'h0;
          c = p0_en && p0_we
            && (p0_addr == p1_addr)
            && (int'(p1_addr) < dep[i]);
          if (c && byp[i])
            r = merge(r, p0_wdata, p0_mask);
          ev1[i][vis] = 1'b1;
          ed1[i][vis] = r;
          ec[i][vis]  = c;
        end
        if (p0_en && p0_we
            && int'(p0_addr) < dep[i])
          mdl[i][p0_addr] = merge(
            mdl[i][p0_addr], p0_wdata, p0_mask);
      end
    end
  endfunction

  task automatic tick();
    obs_t o;
    bit   wr;
    model_edge();
    @(posedge clk);
    #1;
    ecount++;
    if (rst_n) since_rel++;
    for (int i = 0; i < 2; i++) begin
      o  = obs(i);
      wr = rst_n && since_rel >= dep[i];
      checks++;
      if (o.rdy !== wr) begin
        errors++;
        $display("FAIL ready[%0d] e%0d: got %b want %b",
                 i, ecount, o.rdy, wr);
      end
      checks++;
      if (o.v0 !== ev0[i][ecount]) begin
        errors++;
        $display("FAIL p0_rvalid[%0d] e%0d: got %b want %b",
                 i, ecount, o.v0, ev0[i][ecount]);
      end
      if (ev0[i][ecount]) ld0[i] = ed0[i][ecount];
      checks++;
      if (o.d0 !== ld0[i]) begin
        errors++;
        $display("FAIL p0_rdata[%0d] e%0d: got %h want %h",
                 i, ecount, o.d0, ld0[i]);
      end
      checks++;
      if (o.v1 !== ev1[i][ecount]) begin
        errors++;
        $display("FAIL p1_rvalid[%0d] e%0d: got %b want %b",
                 i, ecount, o.v1, ev1[i][ecount]);
      end
      if (ev1[i][ecount]) ld1[i] = ed1[i][ecount];
      checks++;
      if (o.d1 !== ld1[i]) begin
        errors++;
        $display("FAIL p1_rdata[%0d] e%0d: got %h want %h",
                 i, ecount, o.d1, ld1[i]);
      end
      checks++;
      if (o.col !== ec[i][ecount]) begin
        errors++;
        $display("FAIL collision[%0d] e%0d: got %b want %b",
                 i, ecount, o.col, ec[i][ecount]);
      end
    end
  endtask

  task automatic idle();
    p0_en = 1'b0; p0_we = 1'b0; p1_en = 1'b0;
    p0_mask = 4'h0; p0_addr = '0; p1_addr = '0;
    p0_wdata = '0;
  endtask

  task automatic wr0(logic [8:0] a, logic [31:0] d,
                     logic [3:0] m);
    p0_en = 1'b1; p0_we = 1'b1;
    p0_addr = a; p0_wdata = d; p0_mask = m;
  endtask

  task automatic release_and_wait();
    int na = 0;
    int nb = 0;
    rst_n = 1'b1;
    for (int n = 1; n <= 700; n++) begin
      tick();
      if (rdy_b && nb == 0) nb = n;
      if (rdy_a) begin
        na = n;
        break;
      end
    end
    checks++;
    if (na != 512) begin
      errors++;
      $display("FAIL init_len_a: got %0d want 512", na);
    end
    checks++;
    if (nb != 300) begin
      errors++;
      $display("FAIL init_len_b: got %0d want 300", nb);
    end
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    flush();
    #1;
    checks++;
    if ({rdy_a, v0_a, v1_a, col_a, rdy_b, v0_b, v1_b, col_b}
        !== 8'h00) begin
      errors++;
      $display("FAIL rst_flags: got %b want 00000000",
        {rdy_a, v0_a, v1_a, col_a, rdy_b, v0_b, v1_b, col_b});
    end
    checks++;
    if ({d0_a, d1_a, d0_b, d1_b} !== 128'h0) begin
      errors++;
      $display("FAIL rst_data: got %h want 0",
               {d0_a, d1_a, d0_b, d1_b});
    end
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    flush();
    repeat (3) tick();
    assert_reset();
    release_and_wait();
  endtask

  task automatic test_clear();
    p1_en = 1'b1; p1_addr = 9'h000;
    tick();
    checks++;
    if (!(v1_a === 1'b1 && d1_a === 32'h0)) begin
      errors++;
      $display("FAIL clear_0: got %b/%h want 1/0", v1_a, d1_a);
    end
    p1_addr = 9'h1FF;
    tick();
    checks++;
    if (!(v1_a === 1'b1 && d1_a === 32'h0)) begin
      errors++;
      $display("FAIL clear_1ff: got %b/%h want 1/0", v1_a, d1_a);
    end
    idle();
    tick();
  endtask

  task automatic test_mask_write();
    wr0(9'h005, 32'h11223344, 4'b1111);
    tick();
    wr0(9'h005, 32'hAABBCCDD, 4'b0101);
    tick();
    idle();
    p0_en = 1'b1; p0_addr = 9'h005;
    tick();
    idle();
    checks++;
    if (!(v0_a === 1'b1 && d0_a === 32'h11BB33DD)) begin
      errors++;
      $display("FAIL mask_a: got %b/%h want 1/11bb33dd",
               v0_a, d0_a);
    end
    tick();
    checks++;
    if (!(v0_b === 1'b1 && d0_b === 32'h11BB33DD)) begin
      errors++;
      $display("FAIL mask_b: got %b/%h want 1/11bb33dd",
               v0_b, d0_b);
    end
    tick();
  endtask

  task automatic test_collision();
    wr0(9'h010, 32'hDEADBEEF, 4'b1100);
    p1_en = 1'b1; p1_addr = 9'h010;
    tick();
    idle();
    checks++;
    if ({v1_a, col_a, d1_a} !== {2'b11, 32'hDEAD0000}) begin
      errors++;
      $display("FAIL coll_a: got %b%b/%h want 11/dead0000",
               v1_a, col_a, d1_a);
    end
    tick();
    checks++;
    if ({v1_b, col_b, d1_b} !== {2'b11, 32'h0}) begin
      errors++;
      $display("FAIL coll_b: got %b%b/%h want 11/00000000",
               v1_b, col_b, d1_b);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [4];
    for (int k = 0; k < 4; k++) begin
      vals[k] = $urandom;
      wr0(9'(k), vals[k], 4'hF);
      tick();
    end
    idle();
    for (int t = 0; t < 6; t++) begin
      p1_en = (t < 4);
      p1_addr = (t < 4) ? 9'(t) : 9'h0;
      tick();
      checks++;
      if (t >= 1 && t <= 4) begin
        if (!(v1_b === 1'b1 && d1_b === vals[t-1])) begin
          errors++;
          $display("FAIL b2b_%0d: got %b/%h want 1/%h",
                   t, v1_b, d1_b, vals[t-1]);
        end
      end else if (v1_b !== 1'b0) begin
        errors++;
        $display("FAIL b2b_idle_%0d: got %b want 0", t, v1_b);
      end
    end
    idle();
  endtask

  task automatic test_out_of_range();
    wr0(9'h000, 32'h12345678, 4'hF);
    tick();
    wr0(9'h12C, 32'hCAFEF00D, 4'hF);
    tick();
    idle();
    p0_en = 1'b1; p0_addr = 9'h000;
    p1_en = 1'b1; p1_addr = 9'h12C;
    tick();
    idle();
    tick();
    checks++;
    if ({v1_b, d1_b} !== {1'b1, 32'h0}) begin
      errors++;
      $display("FAIL oor_rd: got %b/%h want 1/00000000",
               v1_b, d1_b);
    end
    checks++;
    if ({v0_b, d0_b} !== {1'b1, 32'h12345678}) begin
      errors++;
      $display("FAIL oor_mem0: got %b/%h want 1/12345678",
               v0_b, d0_b);
    end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      p0_en = 1'($urandom_range(0, 1));
      p0_we = 1'($urandom_range(0, 1));
      p0_mask = 4'($urandom);
      p0_wdata = $urandom;
      p0_addr = ($urandom_range(0, 9) < 7)
        ? 9'($urandom_range(0, 15))
        : 9'($urandom_range(290, 310));
      p1_en = 1'($urandom_range(0, 1));
      p1_addr = ($urandom_range(0, 3) == 0)
        ? p0_addr
        : 9'($urandom_range(0, 15));
      tick();
    end
    idle();
    repeat (3) tick();
  endtask

  task automatic test_reset_midop();
    p0_en = 1'b1; p0_addr = 9'h005;
    p1_en = 1'b1; p1_addr = 9'h010;
    tick();
    idle();
    assert_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (100) tick();
    assert_reset();
    repeat (2) tick();
    release_and_wait();
    p0_en = 1'b1; p0_addr = 9'h005;
    tick();
    idle();
    checks++;
    if ({v0_a, d0_a} !== {1'b1, 32'h0}) begin
      errors++;
      $display("FAIL reclear: got %b/%h want 1/00000000",
               v0_a, d0_a);
    end
    repeat (3) tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_clear();
    test_mask_write();
    test_collision();
    test_back_to_back();
    test_out_of_range();
    test_random();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
